// File: rtl/rr_mux_select_pkg.sv
// Shared widths, state encoding and helpers for the round-robin mux select sequencer.
package rr_mux_select_pkg;

  localparam int unsigned SEL_W = 2;
  localparam int unsigned N_IN  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // One-hot decode of a select index.
  function automatic logic [N_IN-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    return N_IN'(1) << sel;
  endfunction

endpackage

// File: rtl/rr_mux_select_dwell_cnt.sv
// Dwell counter: loads a start value, counts down to zero and stops there.
module dwell_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins over decrement; never decrement past zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/rr_mux_select.sv
// Round-robin select sequencer for a 4:1 mux: grants one requester, holds the
// select for a minimum dwell, releases on ack and rotates priority.
module rr_mux_select
  import rr_mux_select_pkg::*;
#(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_IN-1:0]  req,
  input  logic             ack,
  output logic [SEL_W-1:0] s,
  output logic [N_IN-1:0]  grant,
  output logic             valid
);

  localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] s_q, s_d;
  logic [N_IN-1:0]  grant_q, grant_d;
  logic             valid_q, valid_d;

  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero_c;

  logic             found_c;
  logic [SEL_W-1:0] idx_c;
  logic [SEL_W-1:0] cand;

  dwell_cnt #(
    .CNT_W (CNT_W)
  ) u_dwell_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (DWELL_M1),
    .zero_c     (cnt_zero_c)
  );

  // Priority search starting just after the last-served index, wrapping mod 4.
  always_comb begin
    found_c = 1'b0;
    idx_c   = ptr_q;
    cand    = '0;
    for (int unsigned k = 1; k <= N_IN; k++) begin
      cand = ptr_q + SEL_W'(k);
      if (!found_c && req[cand]) begin
        found_c = 1'b1;
        idx_c   = cand;
      end
    end
  end

  // Next-state and output decode; release returns to IDLE with s held.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    s_d      = s_q;
    grant_d  = grant_q;
    valid_d  = valid_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        grant_d = '0;
        if (en && found_c) begin
          s_d      = idx_c;
          grant_d  = sel_onehot(idx_c);
          valid_d  = 1'b1;
          cnt_load = 1'b1;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!cnt_zero_c) begin
          cnt_dec = 1'b1;
        end else if (ack) begin
          ptr_d   = s_q;
          valid_d = 1'b0;
          grant_d = '0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ack) begin
          ptr_d   = s_q;
          valid_d = 1'b0;
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pointer and output registers; index 0 has first priority out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= SEL_W'(N_IN - 1);
      s_q     <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      s_q     <= s_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end

  assign s     = s_q;
  assign grant = grant_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_rr_mux_select.sv
// Bench for rr_mux_select: hand-built cycle table for DWELL=4, a reference
// model for a DWELL=1 instance, and a four_one mux check on both.
module tb_rr_mux_select;
  import rr_mux_select_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, ack;
  logic [3:0] req;
  logic [1:0] s4, s1;
  logic [3:0] g4, g1;
  logic       v4, v1;
  logic [3:0] i_data = 4'b1010;

  rr_mux_select #(.DWELL(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst(rst), .en(en), .req(req), .ack(ack),
    .s(s4), .grant(g4), .valid(v4)
  );

  rr_mux_select #(.DWELL(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .en(en), .req(req), .ack(ack),
    .s(s1), .grant(g1), .valid(v1)
  );

  typedef struct {
    logic [1:0] s;
    logic [3:0] g;
    logic       v;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic       ack;
    exp_t       e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb4[$];
  exp_t sb1[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // DWELL=1 reference model: counts valid cycles up instead of down.
  localparam int M_DW = 1;
  int m_busy, m_sel, m_ptr, m_age;

  task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  function automatic int pick(input int p, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (p + k) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic e, input logic [3:0] q, input logic a);
    int c;
    if (r) begin
      m_busy = 0; m_sel = 0; m_ptr = 3; m_age = 0;
    end else if (m_busy == 0) begin
      c = pick(m_ptr, q);
      if (e && c >= 0) begin
        m_busy = 1; m_sel = c; m_age = 1;
      end
    end else if (m_age >= M_DW && a) begin
      m_busy = 0; m_ptr = m_sel;
    end else begin
      m_age++;
    end
  endtask

  task automatic add(input logic r, input logic e, input logic [3:0] q, input logic a,
                     input logic [1:0] xs, input logic [3:0] xg, input logic xv);
    vec_t v;
    v.rst = r; v.en = e; v.req = q; v.ack = a;
    v.e.s = xs; v.e.g = xg; v.e.v = xv;
    vecs.push_back(v);
  endtask

  // One full DWELL=4 grant with ack high: four valid cycles then one bubble.
  task automatic grant_blk(input logic [3:0] q, input logic [1:0] idx);
    logic [3:0] oh;
    oh = 4'(1) << idx;
    for (int k = 0; k < 4; k++) add(1'b0, 1'b1, q, 1'b1, idx, oh, 1'b1);
    add(1'b0, 1'b1, q, 1'b1, idx, 4'b0000, 1'b0);
  endtask

  initial begin
    exp_t ex;
    exp_t em;

    // Reset and idle, including requests while disabled.
    add(1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0);
    for (int k = 0; k < 4; k++) add(1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1'b0, 1'b0, 4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0);
    add(1'b0, 1'b0, 4'b1111, 1'b0, 2'd0, 4'b0000, 1'b0);
    // req=1010: 1, 3, then wrap back to 1.
    grant_blk(4'b1010, 2'd1);
    grant_blk(4'b1010, 2'd3);
    grant_blk(4'b1010, 2'd1);
    // Reset restores index 0 as first priority; req=1111 rotates 0,1,2,3,0.
    add(1'b1, 1'b1, 4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0);
    grant_blk(4'b1111, 2'd0);
    grant_blk(4'b1111, 2'd1);
    grant_blk(4'b1111, 2'd2);
    grant_blk(4'b1111, 2'd3);
    grant_blk(4'b1111, 2'd0);
    // Early ack ignored, req drop and en drop do not abort, release on late ack.
    add(1'b0, 1'b1, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1);
    add(1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, 4'b0100, 1'b1);
    add(1'b0, 1'b1, 4'b0000, 1'b0, 2'd2, 4'b0100, 1'b1);
    add(1'b0, 1'b1, 4'b0000, 1'b0, 2'd2, 4'b0100, 1'b1);
    for (int k = 0; k < 4; k++) add(1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 4'b0100, 1'b1);
    add(1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 4'b0000, 1'b0);
    add(1'b0, 1'b0, 4'b0100, 1'b0, 2'd2, 4'b0000, 1'b0);
    // Sole requester re-granted, then reset mid-hold discards the grant.
    add(1'b0, 1'b1, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1);
    add(1'b1, 1'b1, 4'b0100, 1'b1, 2'd0, 4'b0000, 1'b0);
    add(1'b0, 1'b1, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1);
    for (int k = 0; k < 3; k++) add(1'b0, 1'b1, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1);
    // req changes together with ack at the release edge: new req served next cycle.
    add(1'b0, 1'b1, 4'b0001, 1'b1, 2'd2, 4'b0000, 1'b0);
    add(1'b0, 1'b1, 4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1);
    add(1'b1, 1'b1, 4'b0001, 1'b0, 2'd0, 4'b0000, 1'b0);

    m_busy = 0; m_sel = 0; m_ptr = 3; m_age = 0;

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      en  = vecs[i].en;
      req = vecs[i].req;
      ack = vecs[i].ack;
      sb4.push_back(vecs[i].e);
      model_step(vecs[i].rst, vecs[i].en, vecs[i].req, vecs[i].ack);
      em.s = 2'(m_sel);
      em.v = (m_busy != 0);
      em.g = em.v ? (4'(1) << em.s) : 4'b0000;
      sb1.push_back(em);

      @(posedge clk);
      #1;

      ex = sb4.pop_front();
      chk("dwell4_s",     i, 8'(s4), 8'(ex.s));
      chk("dwell4_grant", i, 8'(g4), 8'(ex.g));
      chk("dwell4_valid", i, 8'(v4), 8'(ex.v));
      if (ex.v) chk("dwell4_y", i, 8'(i_data[s4]), 8'(i_data[ex.s]));

      em = sb1.pop_front();
      chk("dwell1_s",     i, 8'(s1), 8'(em.s));
      chk("dwell1_grant", i, 8'(g1), 8'(em.g));
      chk("dwell1_valid", i, 8'(v1), 8'(em.v));
      if (em.v) chk("dwell1_y", i, 8'(i_data[s1]), 8'(i_data[em.s]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
